// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // ceil(width * log10(2)) with log10(2) approximated as 0.30103
  function automatic int bcd_digits_for(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before it is doubled.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= BCD_ADJ_THRESH) ? i_digit + BCD_ADJ_ADD : i_digit;

endmodule

// File: rtl/bcd_seq_converter.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one operand bit per clock,
// valid/ready on both sides and a sticky overflow for values beyond DIGITS digits.
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_ovf,
  output logic                  busy
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  if (DIGITS < 1 || BIN_W < 1) begin : g_bad_param
    $fatal(1, "bcd_seq_converter: DIGITS and BIN_W must both be at least 1");
  end

  bcd_state_t         r_state;
  logic [BIN_W-1:0]   r_sreg;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic [ACC_W-1:0]   w_acc_adj;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    bcd_digit_adjust u_adj (
      .i_digit (r_acc[4*gi +: 4]),
      .o_digit (w_acc_adj[4*gi +: 4])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sreg  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sreg  <= in_data;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          // A 1 leaving the top digit is a decimal carry past the last digit
          r_acc   <= {w_acc_adj[ACC_W-2:0], r_sreg[BIN_W-1]};
          r_sreg  <= r_sreg << 1;
          r_ovf   <= r_ovf | w_acc_adj[ACC_W-1];
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state == SHIFT);
  assign out_valid = (r_state == DONE);
  assign out_bcd   = r_acc;
  assign out_ovf   = r_ovf;

endmodule

// File: doc/bcd_seq_converter.md
Name: bcd_seq_converter

Overview:
Iterative binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It is parametrised in input width and BCD digit count. Input and output use valid/ready handshakes, and an overflow flag reports values too large for the configured digit count. It is the sequential, width-generic replacement for the fixed 5-bit combinational converter, and feeds display/decimal-formatting paths.

Parameters:
BIN_W, 16, width of the binary input (legal 1..32)
DIGITS, 5, number of BCD output digits (legal 1..10); output width is 4*DIGITS

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  binary operand present
in_ready  out  1  converter can accept an operand
in_data  in  BIN_W  unsigned binary operand
out_valid  out  1  result held on out_bcd / out_ovf
out_ready  in  1  downstream accepts result
out_bcd  out  4*DIGITS  packed BCD; digit 0 (ones) in [3:0]
out_ovf  out  1  operand > 10^DIGITS-1; out_bcd is then invalid (defined as residue below)
busy  out  1  high in SHIFT state

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); the polarity and synchronicity are fixed.
- States: IDLE, SHIFT, DONE. Encoding is free.
- Reset (sampled on a clk edge while rst=1):
  - state=IDLE, in_ready=1, out_valid=0, busy=0, out_bcd=0, out_ovf=0
  - internal shift register and counter cleared
  - rst overrides every other input, including mid-SHIFT and DONE; any in-flight operand is dropped, with no partial output.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch in_data into the shift register, clear the BCD accumulator and the ovf flag, set counter=0, go to SHIFT.
- SHIFT, one bit per cycle:
  - in_ready=0, busy=1.
  - Each edge:
    - every 4-bit accumulator digit >=5 gets +3 (all digits in parallel, combinational on current value);
    - then {acc, sreg} shifts left 1, with the MSB of sreg entering acc bit 0;
    - the bit shifted out of the top of acc ORs into the sticky ovf;
    - counter increments.
  - On the edge where counter==BIN_W-1 (the BIN_W-th shift): go to DONE.
- DONE:
  - out_valid=1; out_bcd=acc; out_ovf=ovf.
  - Outputs stay stable until out_ready=1 is sampled; that edge goes to IDLE with out_valid=0.
  - in_ready=0 in DONE, so there is no overlap of accept and deliver.
- Latency: in_valid accepted at edge E0; out_valid high after edge E0+BIN_W.
- Throughput: at most one operand per BIN_W+2 cycles with out_ready tied high.
- The overflow residue in out_bcd is the low DIGITS digits of the double-dabble result. It is deterministic but does not represent the value.
- in_data is sampled only at the accept edge; later changes are ignored.
- The add-3 is applied before the shift in the same cycle. No digit ever exceeds 9 in the accumulator after a shift.
- Counter width: clog2(BIN_W)+1 bits. No wrap is reachable.
- Elaboration check: DIGITS<1 or BIN_W<1 is a fatal error.
- With BIN_W=5, DIGITS=2, the result matches the old combinational converter for 0..31 (26..31 give 0x26..0x31, ovf=0).

Decomposition:
- Shared package bcd_pkg holds:
  - state enum type bcd_state_t (IDLE/SHIFT/DONE);
  - constant BCD_ADJ_THRESH=5 and BCD_ADJ_ADD=3;
  - function bcd_digits_for(width), returning ceil(width*log10 2), for callers to size DIGITS.
- One natural sub-module: bcd_digit_adjust. It is purely combinational: 4-bit in, 4-bit out, +3 when >=5. It is instantiated DIGITS times via generate.
- The FSM, shift register, counter and ovf flag stay in bcd_seq_converter.

Test Plan:
1. BIN_W=16, DIGITS=5, out_ready=1: in_data=0 -> out_bcd=20'h00000, ovf=0, out_valid high exactly 16 cycles after accept.
2. BIN_W=16, DIGITS=5: in_data=65535 -> out_bcd=20'h65535, ovf=0. Then in_data=9999 -> 20'h09999.
3. BIN_W=16, DIGITS=4: in_data=9999 -> 16'h9999, ovf=0. Then in_data=12345 -> ovf=1.
4. Backpressure: convert 25, hold out_ready=0 for 7 cycles -> out_valid=1, out_bcd=0x00025 stable, in_ready=0 throughout. in_data toggled meanwhile is ignored. out_ready=1 -> IDLE next edge, in_ready=1.
5. Reset mid-SHIFT: accept 4660, assert rst for 1 cycle after 6 shifts -> next cycle out_valid=0, busy=0, in_ready=1, out_bcd=0. Next operand 42 converts to 0x00042 correctly.
6. BIN_W=5, DIGITS=2: exhaustive sweep 0..31 -> out_bcd equals tens*16+ones for every value, ovf=0. Back-to-back in_valid held high gives one result every 7 cycles.
